// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync + debounce for two active-low buttons, with press/release pulses
// Optional auto-repeat of press pulses while held: define BUTTON_CONDITIONER_AUTOREPEAT_EN.

module button_conditioner_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    input  logic both_held,
`endif
    output logic level_n,
    output logic level_next_n,
    output logic press,
    output logic rel
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARM_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_ARM_REL   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_next;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_base;
    logic             press_next;
    logic             rel_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            state  <= ST_IDLE;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            s1     <= raw_n;
            s2     <= s1;
            state  <= state_next;
            stable <= stable_next;
            cnt    <= cnt_next;
            press  <= press_next;
            rel    <= rel_next;
        end
    end

    // Any sample of s2 agreeing with stable wipes the count, so a bounce restarts the window.
    always_comb begin
        state_next  = state;
        stable_next = stable;
        cnt_next    = '0;
        accept      = 1'b0;
        if (s2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                accept      = 1'b1;
                stable_next = s2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        case (state)
            ST_IDLE: begin
                if (!s2) state_next = ST_ARM_PRESS;
            end
            ST_ARM_PRESS: begin
                if (s2)          state_next = ST_IDLE;
                else if (accept) state_next = ST_HELD;
            end
            ST_HELD: begin
                if (s2) state_next = ST_ARM_REL;
            end
            ST_ARM_REL: begin
                if (!s2)         state_next = ST_HELD;
                else if (accept) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        press_base = accept & stable;
        rel_next   = accept & ~stable;
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [HOLD_W-1:0] hold_limit;
    logic              repeating;
    logic              repeating_next;
    logic              rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else begin
            hold_cnt  <= hold_next;
            repeating <= repeating_next;
        end
    end

    // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit from HELD rearms the delay.
    always_comb begin
        hold_next      = '0;
        repeating_next = 1'b0;
        rep_fire       = 1'b0;
        hold_limit     = repeating ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
        if (state == ST_HELD && !s2) begin
            if (hold_cnt == hold_limit) begin
                rep_fire       = ~both_held;
                repeating_next = 1'b1;
            end else begin
                hold_next      = hold_cnt + 1'b1;
                repeating_next = repeating;
            end
        end
    end

    assign press_next = press_base | rep_fire;
`else
    assign press_next = press_base;
`endif

    assign level_n      = stable;
    assign level_next_n = stable_next;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw_n,
    input  logic btn_down_raw_n,
    output logic up_level_n,
    output logic down_level_n,
    output logic up_press,
    output logic down_press,
    output logic up_release,
    output logic down_release,
    output logic both_held
);

    if (DEBOUNCE_CYCLES < 2 || CNT_W < 1 || CNT_W > 62 ||
        (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: invalid parameter set");
    end

    logic up_level_next_n;
    logic down_level_next_n;

    button_conditioner_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_up (
        .clk         (clk),
        .rst         (rst),
        .raw_n       (btn_up_raw_n),
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        .both_held   (both_held),
`endif
        .level_n     (up_level_n),
        .level_next_n(up_level_next_n),
        .press       (up_press),
        .rel         (up_release)
    );

    button_conditioner_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_down (
        .clk         (clk),
        .rst         (rst),
        .raw_n       (btn_down_raw_n),
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        .both_held   (both_held),
`endif
        .level_n     (down_level_n),
        .level_next_n(down_level_next_n),
        .press       (down_press),
        .rel         (down_release)
    );

    // Built from the next-state levels so it moves on the same edge as the second acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            both_held <= 1'b0;
        end else begin
            both_held <= ~up_level_next_n & ~down_level_next_n;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner

module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk;
    logic rst;
    logic btn_up_raw_n;
    logic btn_down_raw_n;
    logic up_level_n;
    logic down_level_n;
    logic up_press;
    logic down_press;
    logic up_release;
    logic down_release;
    logic both_held;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_up_raw_n  (btn_up_raw_n),
        .btn_down_raw_n(btn_down_raw_n),
        .up_level_n    (up_level_n),
        .down_level_n  (down_level_n),
        .up_press      (up_press),
        .down_press    (down_press),
        .up_release    (up_release),
        .down_release  (down_release),
        .both_held     (both_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int up_press_cnt;
    int down_press_cnt;

    // Model: raw sample history per button; a level flips once the last D synchronizer
    // outputs (raw delayed two edges) all disagree with it and D edges have passed since it last flipped.
    logic [15:0] hist [0:1];
    logic        m_stable [0:1];
    logic        m_press [0:1];
    logic        m_rel [0:1];
    int          since [0:1];
    int          run [0:1];
    logic        m_both;

    task m_reset;
        for (int c = 0; c < 2; c++) begin
            hist[c]     = 16'hFFFF;
            m_stable[c] = 1'b1;
            m_press[c]  = 1'b0;
            m_rel[c]    = 1'b0;
            since[c]    = 0;
            run[c]      = 0;
        end
        m_both = 1'b0;
    endtask

    task m_step;
        logic acc;
        logic old;
        logic rawv;
        for (int c = 0; c < 2; c++) begin
            rawv = (c == 0) ? btn_up_raw_n : btn_down_raw_n;
            old  = m_stable[c];
            if (since[c] < 1000) since[c]++;
            acc = (since[c] >= D);
            for (int j = 1; j <= D; j++) begin
                if (hist[c][j] == old) acc = 1'b0;
            end
            if (acc) begin
                m_stable[c] = ~old;
                since[c]    = 0;
            end
            m_press[c] = acc & old;
            m_rel[c]   = acc & ~old;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            if (!old && !hist[c][1] && !hist[c][2]) run[c]++;
            else run[c] = 0;
            if (run[c] >= RD && ((run[c] - RD) % RP) == 0 && !m_both) m_press[c] = 1'b1;
`endif
            hist[c] = {hist[c][14:0], rawv};
        end
        m_both = ~m_stable[0] & ~m_stable[1];
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            total++;
            if ({up_level_n, down_level_n, up_press, down_press, up_release, down_release, both_held} !==
                {m_stable[0], m_stable[1], m_press[0], m_press[1], m_rel[0], m_rel[1], m_both}) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual=%b required=%b", $time,
                    {up_level_n, down_level_n, up_press, down_press, up_release, down_release, both_held},
                    {m_stable[0], m_stable[1], m_press[0], m_press[1], m_rel[0], m_rel[1], m_both});
            end
            if (up_press === 1'b1) up_press_cnt++;
            if (down_press === 1'b1) down_press_cnt++;
        end
    end

    task step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int n0;

    initial begin : stim
        total = 0;
        bad = 0;
        up_press_cnt = 0;
        down_press_cnt = 0;
        rst = 1'b1;
        btn_up_raw_n = 1'b0;
        btn_down_raw_n = 1'b0;
        step(3);
        check("rst_up_level", 32'(up_level_n), 1);
        check("rst_down_level", 32'(down_level_n), 1);
        check("rst_pulses", 32'({up_press, down_press, up_release, down_release, both_held}), 0);

        // both held through reset release: accepted together on edge 6
        rst = 1'b0;
        step(5);
        check("pre_accept_up_level", 32'(up_level_n), 1);
        step(1);
        check("accept_up_level", 32'(up_level_n), 0);
        check("accept_presses", 32'({up_press, down_press}), 32'b11);
        check("accept_both_held", 32'(both_held), 1);
        step(1);
        check("press_one_cycle", 32'({up_press, down_press}), 0);

        btn_down_raw_n = 1'b1;
        step(5);
        check("down_rel_pre", 32'({down_level_n, both_held}), 32'b01);
        step(1);
        check("down_rel_accept", 32'({down_level_n, down_release, both_held}), 32'b110);

        btn_up_raw_n = 1'b1;
        step(6);
        check("up_rel_accept", 32'({up_level_n, up_release}), 32'b11);

        // 3-cycle glitch never qualifies
        n0 = up_press_cnt;
        btn_up_raw_n = 1'b0;
        step(3);
        btn_up_raw_n = 1'b1;
        step(10);
        check("glitch_level", 32'(up_level_n), 1);
        check("glitch_presses", 32'(up_press_cnt - n0), 0);

        // bounce then settle low
        n0 = up_press_cnt;
        repeat (2) begin
            btn_up_raw_n = 1'b0;
            step(2);
            btn_up_raw_n = 1'b1;
            step(2);
        end
        btn_up_raw_n = 1'b0;
        step(5);
        check("bounce_pre_level", 32'(up_level_n), 1);
        step(1);
        check("bounce_accept", 32'({up_level_n, up_press}), 32'b01);
        step(4);
        check("bounce_presses", 32'(up_press_cnt - n0), 1);
        btn_up_raw_n = 1'b1;
        step(8);

        // reset while the up counter sits at 2
        btn_up_raw_n = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        check("midrst_level", 32'({up_level_n, up_press}), 32'b10);
        rst = 1'b0;
        step(5);
        check("midrst_pre_level", 32'(up_level_n), 1);
        step(1);
        check("midrst_accept", 32'({up_level_n, up_press}), 32'b01);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        n0 = up_press_cnt;
        step(30);
        check("repeat_presses", 32'(up_press_cnt - n0), 7);
        btn_down_raw_n = 1'b0;
        step(6);
        check("repeat_both_held", 32'(both_held), 1);
        n0 = up_press_cnt;
        step(20);
        check("repeat_suppressed", 32'(up_press_cnt - n0), 0);
`else
        n0 = up_press_cnt;
        step(40);
        check("no_repeat", 32'(up_press_cnt - n0), 0);
`endif

        btn_up_raw_n = 1'b1;
        btn_down_raw_n = 1'b1;
        step(8);
        check("final_levels", 32'({up_level_n, down_level_n, both_held}), 32'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
